voice_allocator: RTL

- Polyphonic voice scheduler between the MIDI byte/message decoder and the voice bank (oscillator/envelope slots).
- Takes decoded note-on/note-off messages and assigns each note to one of NUM_VOICES voice slots.
- Releases the slot on note-off and steals the oldest slot when the bank is full.
- Drives a one-write-per-message update port into the voice bank and raises a sticky interrupt for the processor.

---
 rtl/voice_allocator.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: scans all slots per message, then commits
// one write into the voice bank (retrigger, allocate, steal or release).
module voice_allocator #(
    parameter int NUM_VOICES = 16,
    parameter int VOICE_W    = 4,
    parameter int AGE_W      = 8,
    parameter bit STEAL_EN   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  msg_valid,
    output logic                  msg_ready,
    input  logic                  msg_is_on,
    input  logic [3:0]            msg_chan,
    input  logic [6:0]            msg_note,
    input  logic [6:0]            msg_vel,
    output logic                  voice_we,
    output logic [VOICE_W-1:0]    voice_idx,
    output logic [6:0]            voice_note,
    output logic [6:0]            voice_vel,
    output logic                  voice_gate,
    output logic [NUM_VOICES-1:0] active_mask,
    input  logic                  irq_en,
    input  logic                  irq_clr,
    output logic                  irq,
    output logic [7:0]            drop_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT
    } state_t;

    localparam logic [VOICE_W-1:0] LAST = VOICE_W'(NUM_VOICES - 1);
    localparam logic [AGE_W-1:0]   AGE_MAX = {AGE_W{1'b1}};

    state_t state_q;

    logic [VOICE_W-1:0]    scan_q;
    logic                  l_on_q;
    logic [3:0]            l_chan_q;
    logic [6:0]            l_note_q;
    logic [6:0]            l_vel_q;

    logic [3:0]            chan_q [NUM_VOICES];
    logic [6:0]            note_q [NUM_VOICES];
    logic [AGE_W-1:0]      age_q  [NUM_VOICES];
    logic [NUM_VOICES-1:0] act_q;

    logic                  m_f_q, m_f_d;
    logic [VOICE_W-1:0]    m_idx_q, m_idx_d;
    logic                  f_f_q, f_f_d;
    logic [VOICE_W-1:0]    f_idx_q, f_idx_d;
    logic                  o_f_q, o_f_d;
    logic [VOICE_W-1:0]    o_idx_q, o_idx_d;
    logic [AGE_W-1:0]      o_age_q, o_age_d;

    logic                  ready_q;
    logic                  we_q;
    logic                  drop_q;
    logic [VOICE_W-1:0]    idx_q;
    logic [6:0]            vnote_q;
    logic [6:0]            vvel_q;
    logic                  gate_q;
    logic                  irq_q;
    logic [7:0]            drop_cnt_q;

    logic                  hit;
    logic                  last;
    logic                  wr;
    logic                  drop;
    logic [VOICE_W-1:0]    tgt;

    assign msg_ready   = ready_q;
    assign voice_we    = we_q;
    assign voice_idx   = idx_q;
    assign voice_note  = vnote_q;
    assign voice_vel   = vvel_q;
    assign voice_gate  = gate_q;
    assign active_mask = act_q;
    assign irq         = irq_q;
    assign drop_cnt    = drop_cnt_q;

    assign last = (state_q == SCAN) && (scan_q == LAST);

    // Fold the slot under the scan pointer into the running records
    always_comb begin
        hit = act_q[scan_q]
            && (chan_q[scan_q] == l_chan_q)
            && (note_q[scan_q] == l_note_q);
        m_f_d   = m_f_q;
        m_idx_d = m_idx_q;
        f_f_d   = f_f_q;
        f_idx_d = f_idx_q;
        o_f_d   = o_f_q;
        o_idx_d = o_idx_q;
        o_age_d = o_age_q;
        if (hit && !m_f_q) begin
            m_f_d   = 1'b1;
            m_idx_d = scan_q;
        end
        if (!act_q[scan_q] && !f_f_q) begin
            f_f_d   = 1'b1;
            f_idx_d = scan_q;
        end
        if (act_q[scan_q] && (!o_f_q || age_q[scan_q] > o_age_q)) begin
            o_f_d   = 1'b1;
            o_idx_d = scan_q;
            o_age_d = age_q[scan_q];
        end
    end

    always_comb begin
        wr   = 1'b0;
        drop = 1'b0;
        tgt  = '0;
        if (l_on_q) begin
            if (m_f_d) begin
                wr  = 1'b1;
                tgt = m_idx_d;
            end else if (f_f_d) begin
                wr  = 1'b1;
                tgt = f_idx_d;
            end else begin
                drop = 1'b1;
                if (STEAL_EN) begin
                    wr  = 1'b1;
                    tgt = o_idx_d;
                end
            end
        end else if (m_f_d) begin
            wr  = 1'b1;
            tgt = m_idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            scan_q     <= '0;
            l_on_q     <= 1'b0;
            l_chan_q   <= '0;
            l_note_q   <= '0;
            l_vel_q    <= '0;
            act_q      <= '0;
            m_f_q      <= 1'b0;
            m_idx_q    <= '0;
            f_f_q      <= 1'b0;
            f_idx_q    <= '0;
            o_f_q      <= 1'b0;
            o_idx_q    <= '0;
            o_age_q    <= '0;
            ready_q    <= 1'b1;
            we_q       <= 1'b0;
            drop_q     <= 1'b0;
            idx_q      <= '0;
            vnote_q    <= '0;
            vvel_q     <= '0;
            gate_q     <= 1'b0;
            irq_q      <= 1'b0;
            drop_cnt_q <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                chan_q[i] <= '0;
                note_q[i] <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            we_q   <= 1'b0;
            drop_q <= 1'b0;
            // A new event outranks a clear landing on the same edge
            if (irq_en && (we_q || drop_q)) begin
                irq_q <= 1'b1;
            end else if (irq_clr) begin
                irq_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (msg_valid) begin
                        state_q  <= SCAN;
                        ready_q  <= 1'b0;
                        scan_q   <= '0;
                        l_on_q   <= msg_is_on && (msg_vel != 7'd0);
                        l_chan_q <= msg_chan;
                        l_note_q <= msg_note;
                        l_vel_q  <= msg_vel;
                        m_f_q    <= 1'b0;
                        f_f_q    <= 1'b0;
                        o_f_q    <= 1'b0;
                        m_idx_q  <= '0;
                        f_idx_q  <= '0;
                        o_idx_q  <= '0;
                        o_age_q  <= '0;
                    end
                end
                SCAN: begin
                    scan_q  <= scan_q + VOICE_W'(1);
                    m_f_q   <= m_f_d;
                    m_idx_q <= m_idx_d;
                    f_f_q   <= f_f_d;
                    f_idx_q <= f_idx_d;
                    o_f_q   <= o_f_d;
                    o_idx_q <= o_idx_d;
                    o_age_q <= o_age_d;
                    if (last) begin
                        state_q <= COMMIT;
                        if (wr) begin
                            we_q    <= 1'b1;
                            idx_q   <= tgt;
                            vnote_q <= l_note_q;
                            vvel_q  <= l_vel_q;
                            gate_q  <= l_on_q;
                            if (l_on_q) begin
                                for (int i = 0; i < NUM_VOICES; i++) begin
                                    if (VOICE_W'(i) == tgt) begin
                                        age_q[i] <= '0;
                                    end else if (act_q[i] && age_q[i] != AGE_MAX) begin
                                        age_q[i] <= age_q[i] + AGE_W'(1);
                                    end
                                end
                                act_q[tgt]  <= 1'b1;
                                chan_q[tgt] <= l_chan_q;
                                note_q[tgt] <= l_note_q;
                            end else begin
                                act_q[tgt] <= 1'b0;
                                age_q[tgt] <= '0;
                            end
                        end
                        if (drop) begin
                            drop_q <= 1'b1;
                            if (drop_cnt_q != 8'hFF) begin
                                drop_cnt_q <= drop_cnt_q + 8'd1;
                            end
                        end
                    end
                end
                COMMIT: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule
